// File: rtl/branch_resolve_unit_if.sv
// Bus between the ID stage and branch_resolve_unit.
// TakenCount/NotTakenCount exist only when BRU_BRANCH_STATS_EN is defined.
interface branch_resolve_unit_if;
    logic [31:0] Instruction;
    logic        InstrValid;
    logic [31:0] RsData;
    logic [31:0] RtData;
    logic        ExRegWrite;
    logic [4:0]  ExDest;
    logic        MemRegWrite;
    logic        MemRead;
    logic [4:0]  MemDest;

    logic        stall;
    logic        branch;
    logic [15:0] branchAmount;
    logic        jumpRegister;
    logic [31:0] Register;
    logic        Flush;
    logic        HoldTimeout;

`ifdef BRU_BRANCH_STATS_EN
    logic [15:0] TakenCount;
    logic [15:0] NotTakenCount;

    modport master (
        output Instruction, InstrValid, RsData, RtData, ExRegWrite, ExDest,
               MemRegWrite, MemRead, MemDest,
        input  stall, branch, branchAmount, jumpRegister, Register, Flush,
               HoldTimeout, TakenCount, NotTakenCount
    );

    modport slave (
        input  Instruction, InstrValid, RsData, RtData, ExRegWrite, ExDest,
               MemRegWrite, MemRead, MemDest,
        output stall, branch, branchAmount, jumpRegister, Register, Flush,
               HoldTimeout, TakenCount, NotTakenCount
    );
`else
    modport master (
        output Instruction, InstrValid, RsData, RtData, ExRegWrite, ExDest,
               MemRegWrite, MemRead, MemDest,
        input  stall, branch, branchAmount, jumpRegister, Register, Flush,
               HoldTimeout
    );

    modport slave (
        input  Instruction, InstrValid, RsData, RtData, ExRegWrite, ExDest,
               MemRegWrite, MemRead, MemDest,
        output stall, branch, branchAmount, jumpRegister, Register, Flush,
               HoldTimeout
    );
`endif
endinterface

// File: rtl/branch_resolve_unit.sv
// ID-stage resolver for conditional branches and jr: holds on in-flight operands,
// then redirects the PC and flushes IF/ID. Optional statistics: BRU_BRANCH_STATS_EN.
module branch_resolve_unit #(
    parameter int MAX_HOLD = 4
) (
    input  logic                 Clk,
    input  logic                 Reset,
    branch_resolve_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, HOLD, REDIRECT} state_t;

    localparam logic [2:0] HOLD_SAT   = 3'd7;
    // The hold counter saturates at 7, so larger limits are clamped to stay reachable.
    localparam logic [2:0] HOLD_LIMIT = (MAX_HOLD > 7) ? 3'd7 : 3'(MAX_HOLD);

    logic [5:0] w_opcode;
    logic [5:0] w_funct;
    logic [4:0] w_rs;
    logic [4:0] w_rt;

    assign w_opcode = bus.Instruction[31:26];
    assign w_rs     = bus.Instruction[25:21];
    assign w_rt     = bus.Instruction[20:16];
    assign w_funct  = bus.Instruction[5:0];

    logic w_is_beq, w_is_bne, w_is_blez, w_is_bgtz, w_is_bltz, w_is_bgez, w_is_jr;
    logic w_is_cond, w_is_ctrl, w_needs_rt;

    assign w_is_beq   = bus.InstrValid && (w_opcode == 6'b000100);
    assign w_is_bne   = bus.InstrValid && (w_opcode == 6'b000101);
    assign w_is_blez  = bus.InstrValid && (w_opcode == 6'b000110) && (w_rt == 5'd0);
    assign w_is_bgtz  = bus.InstrValid && (w_opcode == 6'b000111) && (w_rt == 5'd0);
    assign w_is_bltz  = bus.InstrValid && (w_opcode == 6'b000001) && (w_rt == 5'd0);
    assign w_is_bgez  = bus.InstrValid && (w_opcode == 6'b000001) && (w_rt == 5'd1);
    assign w_is_jr    = bus.InstrValid && (w_opcode == 6'b000000) && (w_funct == 6'b001000);
    assign w_is_cond  = w_is_beq | w_is_bne | w_is_blez | w_is_bgtz | w_is_bltz | w_is_bgez;
    assign w_is_ctrl  = w_is_cond | w_is_jr;
    assign w_needs_rt = w_is_beq | w_is_bne;

    // Source 0 is rs (needed by every control instruction), source 1 is rt.
    logic [1:0][4:0] w_src;
    logic [1:0]      w_need;
    logic [1:0]      w_src_haz;
    logic            w_hazard;

    assign w_src[0]  = w_rs;
    assign w_src[1]  = w_rt;
    assign w_need[0] = w_is_ctrl;
    assign w_need[1] = w_needs_rt;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src_haz
            assign w_src_haz[gi] = w_need[gi] && (w_src[gi] != 5'd0) &&
                ((bus.ExRegWrite && (bus.ExDest == w_src[gi])) ||
                 (bus.MemRegWrite && bus.MemRead && (bus.MemDest == w_src[gi])));
        end
    endgenerate

    assign w_hazard = |w_src_haz;

    logic w_eq, w_rs_neg, w_rs_zero, w_taken;

    assign w_eq      = (bus.RsData == bus.RtData);
    assign w_rs_neg  = bus.RsData[31];
    assign w_rs_zero = (bus.RsData == 32'd0);

    always_comb begin
        w_taken = 1'b0;
        if (w_is_beq)       w_taken = w_eq;
        else if (w_is_bne)  w_taken = !w_eq;
        else if (w_is_blez) w_taken = w_rs_neg || w_rs_zero;
        else if (w_is_bgtz) w_taken = !w_rs_neg && !w_rs_zero;
        else if (w_is_bltz) w_taken = w_rs_neg;
        else if (w_is_bgez) w_taken = !w_rs_neg;
        else if (w_is_jr)   w_taken = 1'b1;
    end

    state_t      r_state, w_state_next;
    logic        r_stall, w_stall_next;
    logic        r_branch, w_branch_next;
    logic        r_jump, w_jump_next;
    logic        r_flush, w_flush_next;
    logic [15:0] r_amount, w_amount_next;
    logic [31:0] r_register, w_register_next;
    logic [2:0]  r_hold_cnt, w_hold_cnt_next, w_hold_inc;
    logic        r_timeout, w_timeout_next;

    assign w_hold_inc = (r_hold_cnt == HOLD_SAT) ? HOLD_SAT : r_hold_cnt + 3'd1;

    always_comb begin
        w_state_next    = r_state;
        w_stall_next    = 1'b0;
        w_branch_next   = 1'b0;
        w_jump_next     = 1'b0;
        w_flush_next    = 1'b0;
        w_amount_next   = r_amount;
        w_register_next = r_register;
        w_hold_cnt_next = 3'd0;
        w_timeout_next  = r_timeout;

        case (r_state)
            IDLE, HOLD: begin
                if (!w_is_ctrl) begin
                    w_state_next = IDLE;
                end else if (w_hazard) begin
                    w_state_next    = HOLD;
                    w_stall_next    = 1'b1;
                    w_hold_cnt_next = (r_state == HOLD) ? w_hold_inc : 3'd1;
                    if (w_hold_cnt_next >= HOLD_LIMIT) begin
                        w_timeout_next = 1'b1;
                    end
                end else if (w_taken) begin
                    w_state_next    = REDIRECT;
                    w_branch_next   = w_is_cond;
                    w_jump_next     = w_is_jr;
                    w_flush_next    = 1'b1;
                    w_amount_next   = bus.Instruction[15:0];
                    w_register_next = bus.RsData;
                end else begin
                    w_state_next = IDLE;
                end
            end
            // The IF/ID slot here is the squashed wrong-path fetch.
            REDIRECT: w_state_next = IDLE;
            default:  w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= IDLE;
            r_stall    <= 1'b0;
            r_branch   <= 1'b0;
            r_jump     <= 1'b0;
            r_flush    <= 1'b0;
            r_amount   <= 16'd0;
            r_register <= 32'd0;
            r_hold_cnt <= 3'd0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_stall    <= w_stall_next;
            r_branch   <= w_branch_next;
            r_jump     <= w_jump_next;
            r_flush    <= w_flush_next;
            r_amount   <= w_amount_next;
            r_register <= w_register_next;
            r_hold_cnt <= w_hold_cnt_next;
            r_timeout  <= w_timeout_next;
        end
    end

    assign bus.stall        = r_stall;
    assign bus.branch       = r_branch;
    assign bus.branchAmount = r_amount;
    assign bus.jumpRegister = r_jump;
    assign bus.Register     = r_register;
    assign bus.Flush        = r_flush;
    assign bus.HoldTimeout  = r_timeout;

`ifdef BRU_BRANCH_STATS_EN
    logic        w_cond_resolved;
    logic [15:0] r_taken_cnt;
    logic [15:0] r_not_taken_cnt;

    assign w_cond_resolved = (r_state != REDIRECT) && w_is_cond && !w_hazard;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_taken_cnt     <= 16'd0;
            r_not_taken_cnt <= 16'd0;
        end else if (w_cond_resolved) begin
            if (w_taken) r_taken_cnt     <= r_taken_cnt + 16'd1;
            else         r_not_taken_cnt <= r_not_taken_cnt + 16'd1;
        end
    end

    assign bus.TakenCount    = r_taken_cnt;
    assign bus.NotTakenCount = r_not_taken_cnt;
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against an instruction-level reference model.
module tb_branch_resolve_unit;
    localparam int MAX_HOLD = 4;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    branch_resolve_unit_if bus();

    branch_resolve_unit #(.MAX_HOLD(MAX_HOLD)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // 0 = not a control instruction, 1 = conditional branch, 2 = jr
    function automatic int kind_of(input logic [31:0] ins, input logic v);
        if (!v) return 0;
        case (ins[31:26])
            6'd4, 6'd5: return 1;
            6'd6, 6'd7: return (ins[20:16] == 5'd0) ? 1 : 0;
            6'd1:       return (ins[20:16] <= 5'd1) ? 1 : 0;
            6'd0:       return (ins[5:0] == 6'd8) ? 2 : 0;
            default:    return 0;
        endcase
    endfunction

    function automatic bit taken_of(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
        int s;
        s = rs;
        case (ins[31:26])
            6'd4:    return rs == rt;
            6'd5:    return rs != rt;
            6'd6:    return s <= 0;
            6'd7:    return s > 0;
            6'd1:    return ins[16] ? (s >= 0) : (s < 0);
            default: return 1'b1;
        endcase
    endfunction

    function automatic bit hazard_of(input logic [31:0] ins, input logic exw, input logic [4:0] exd,
                                     input logic mw, input logic mr, input logic [4:0] md);
        logic [4:0] srcs[$];
        srcs.push_back(ins[25:21]);
        if (ins[31:26] == 6'd4 || ins[31:26] == 6'd5) srcs.push_back(ins[20:16]);
        foreach (srcs[i]) begin
            if (srcs[i] != 5'd0 && ((exw && exd == srcs[i]) || (mw && mr && md == srcs[i])))
                return 1'b1;
        end
        return 1'b0;
    endfunction

    logic        e_stall = 0, e_branch = 0, e_jr = 0, e_flush = 0, e_to = 0;
    logic [15:0] e_amt = 0;
    logic [31:0] e_reg = 0;
    int          run = 0;
`ifdef BRU_BRANCH_STATS_EN
    logic [15:0] e_tc = 0, e_ntc = 0;
`endif

    always @(posedge Clk) begin
        if (Reset) begin
            e_stall <= 0; e_branch <= 0; e_jr <= 0; e_flush <= 0; e_to <= 0;
            e_amt <= 0; e_reg <= 0; run <= 0;
`ifdef BRU_BRANCH_STATS_EN
            e_tc <= 0; e_ntc <= 0;
`endif
        end else if (e_flush || kind_of(bus.Instruction, bus.InstrValid) == 0) begin
            // slot after a redirect is wrong-path; non-control instructions do nothing
            e_stall <= 0; e_branch <= 0; e_jr <= 0; e_flush <= 0; run <= 0;
        end else if (hazard_of(bus.Instruction, bus.ExRegWrite, bus.ExDest,
                               bus.MemRegWrite, bus.MemRead, bus.MemDest)) begin
            e_stall <= 1; e_branch <= 0; e_jr <= 0; e_flush <= 0;
            run <= run + 1;
            if (run + 1 >= MAX_HOLD) e_to <= 1;
        end else begin
            e_stall <= 0; run <= 0;
            if (taken_of(bus.Instruction, bus.RsData, bus.RtData)) begin
                e_branch <= (kind_of(bus.Instruction, bus.InstrValid) == 1);
                e_jr     <= (kind_of(bus.Instruction, bus.InstrValid) == 2);
                e_flush  <= 1;
                e_amt    <= bus.Instruction[15:0];
                e_reg    <= bus.RsData;
            end else begin
                e_branch <= 0; e_jr <= 0; e_flush <= 0;
            end
`ifdef BRU_BRANCH_STATS_EN
            if (kind_of(bus.Instruction, bus.InstrValid) == 1) begin
                if (taken_of(bus.Instruction, bus.RsData, bus.RtData)) e_tc <= e_tc + 16'd1;
                else                                                   e_ntc <= e_ntc + 16'd1;
            end
`endif
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge Clk) begin
        chk("stall",        32'(bus.stall),        32'(e_stall));
        chk("branch",       32'(bus.branch),       32'(e_branch));
        chk("jumpRegister", 32'(bus.jumpRegister), 32'(e_jr));
        chk("Flush",        32'(bus.Flush),        32'(e_flush));
        chk("branchAmount", 32'(bus.branchAmount), 32'(e_amt));
        chk("Register",     bus.Register,          e_reg);
        chk("HoldTimeout",  32'(bus.HoldTimeout),  32'(e_to));
        chk("exclusive",    32'(bus.branch & bus.jumpRegister), 32'd0);
`ifdef BRU_BRANCH_STATS_EN
        chk("TakenCount",    32'(bus.TakenCount),    32'(e_tc));
        chk("NotTakenCount", 32'(bus.NotTakenCount), 32'(e_ntc));
`endif
        if (bus.branch || bus.jumpRegister)
            $display("redirect t=%0t branch=%0b jr=%0b amount=0x%04h target=0x%08h",
                     $time, bus.branch, bus.jumpRegister, bus.branchAmount, bus.Register);
    end

    // ---------------- stimulus ----------------
    function automatic logic [31:0] pick_data();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rs  = 5'($urandom_range(0, 7));
        logic [4:0]  rt  = 5'($urandom_range(0, 7));
        logic [15:0] imm = 16'($urandom);
        case ($urandom_range(0, 7))
            0:       return {6'd4, rs, rt, imm};
            1:       return {6'd5, rs, rt, imm};
            2:       return {6'd6, rs, ($urandom_range(0, 3) == 0) ? rt : 5'd0, imm};
            3:       return {6'd7, rs, ($urandom_range(0, 3) == 0) ? rt : 5'd0, imm};
            4, 5:    return {6'd1, rs, 5'($urandom_range(0, 2)), imm};
            6:       return {6'd0, rs, rt, imm[15:6], 6'd8};
            default: return $urandom;
        endcase
    endfunction

    task automatic clear_hazards();
        bus.ExRegWrite = 0; bus.ExDest = 0;
        bus.MemRegWrite = 0; bus.MemRead = 0; bus.MemDest = 0;
    endtask

    localparam logic [31:0] BEQ_1_2_8  = 32'h1022_0008;  // beq $1,$2,+8
    localparam logic [31:0] BNE_3_4    = 32'h1464_000C;  // bne $3,$4,+12
    localparam logic [31:0] JR_31      = 32'h03E0_0008;  // jr $31
    localparam logic [31:0] BLTZ_5     = 32'h04A0_FFFC;  // bltz $5,-4
    localparam logic [31:0] BEQ_1_2_4  = 32'h1022_0004;  // beq $1,$2,+4
    localparam logic [31:0] NOP        = 32'h0000_0000;

    initial begin
        Reset = 1;
        bus.Instruction = BEQ_1_2_8; bus.InstrValid = 1;
        bus.RsData = 32'd5; bus.RtData = 32'd5;
        clear_hazards();

        // Reset held for two cycles while a taken beq is presented
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        chk("reset_stall",  32'(bus.stall), 32'd0);
        chk("reset_branch", 32'(bus.branch), 32'd0);
        chk("reset_flush",  32'(bus.Flush), 32'd0);
        chk("reset_to",     32'(bus.HoldTimeout), 32'd0);
        $display("txn reset: outputs checked");
        Reset = 0;

        // beq taken, then the wrong-path slot, then back-to-back beq taken again
        @(negedge Clk);
        chk("beq_branch", 32'(bus.branch), 32'd1);
        chk("beq_amount", 32'(bus.branchAmount), 32'h0008);
        chk("beq_flush",  32'(bus.Flush), 32'd1);
        @(negedge Clk);
        chk("beq_slot_branch", 32'(bus.branch), 32'd0);
        chk("beq_slot_flush",  32'(bus.Flush), 32'd0);
        @(negedge Clk);
        chk("beq_b2b_branch", 32'(bus.branch), 32'd1);
        $display("txn beq: taken twice around a squashed slot");

        // bne with equal operands: not taken (first cycle is the squashed slot)
        bus.Instruction = BNE_3_4; bus.RsData = 32'd7; bus.RtData = 32'd7;
        @(negedge Clk);
        @(negedge Clk);
        chk("bne_branch", 32'(bus.branch), 32'd0);
        chk("bne_stall",  32'(bus.stall), 32'd0);
        $display("txn bne: not taken");

        // jr $31 held by an EX-stage writer for two cycles
        bus.Instruction = JR_31; bus.RsData = 32'h0000_0040;
        bus.ExRegWrite = 1; bus.ExDest = 5'd31;
        @(negedge Clk);
        chk("jr_stall1", 32'(bus.stall), 32'd1);
        @(negedge Clk);
        chk("jr_stall2", 32'(bus.stall), 32'd1);
        clear_hazards();
        @(negedge Clk);
        chk("jr_pulse", 32'(bus.jumpRegister), 32'd1);
        chk("jr_reg",   bus.Register, 32'h0000_0040);
        chk("jr_stall_fall", 32'(bus.stall), 32'd0);
        $display("txn jr: resolved after two hold cycles");
        bus.Instruction = NOP;
        @(negedge Clk);

        // bltz held by a load for five cycles: timeout at the fourth hold cycle
        bus.Instruction = BLTZ_5; bus.RsData = 32'hFFFF_FFFF;
        bus.MemRegWrite = 1; bus.MemRead = 1; bus.MemDest = 5'd5;
        for (int i = 1; i <= 5; i++) begin
            @(negedge Clk);
            chk("bltz_stall", 32'(bus.stall), 32'd1);
            chk("bltz_timeout", 32'(bus.HoldTimeout), (i >= 4) ? 32'd1 : 32'd0);
        end
        clear_hazards();
        @(negedge Clk);
        chk("bltz_branch",  32'(bus.branch), 32'd1);
        chk("bltz_to_kept", 32'(bus.HoldTimeout), 32'd1);
`ifdef BRU_BRANCH_STATS_EN
        chk("stats_taken",     32'(bus.TakenCount), 32'd3);
        chk("stats_not_taken", 32'(bus.NotTakenCount), 32'd1);
`endif
        bus.Instruction = NOP;
        @(negedge Clk);
        chk("bltz_to_sticky", 32'(bus.HoldTimeout), 32'd1);
        $display("txn bltz: timeout raised and kept");

        // Reset in the middle of a hold
        bus.Instruction = BEQ_1_2_4; bus.ExRegWrite = 1; bus.ExDest = 5'd1;
        @(negedge Clk);
        chk("mid_hold_stall", 32'(bus.stall), 32'd1);
        Reset = 1;
        @(negedge Clk);
        chk("rst_hold_stall", 32'(bus.stall), 32'd0);
        chk("rst_hold_to",    32'(bus.HoldTimeout), 32'd0);
`ifdef BRU_BRANCH_STATS_EN
        chk("rst_hold_taken", 32'(bus.TakenCount), 32'd0);
`endif
        $display("txn reset-in-hold: cleared");
        Reset = 0; clear_hazards(); bus.Instruction = NOP;

        // Randomized traffic; IF/ID is held while the model expects a stall
        for (int c = 0; c < 1500; c++) begin
            @(negedge Clk);
            Reset = ($urandom_range(0, 149) == 0);
            if (!e_stall) begin
                bus.Instruction = rand_instr();
                bus.InstrValid  = ($urandom_range(0, 9) != 0);
            end
            bus.RsData      = pick_data();
            bus.RtData      = ($urandom_range(0, 1) == 1) ? bus.RsData : pick_data();
            bus.ExRegWrite  = ($urandom_range(0, 2) == 0);
            bus.ExDest      = 5'($urandom_range(0, 7));
            bus.MemRegWrite = ($urandom_range(0, 1) == 1);
            bus.MemRead     = ($urandom_range(0, 2) == 0);
            bus.MemDest     = 5'($urandom_range(0, 7));
        end
        @(negedge Clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
